// File: rtl/sram_req_arbiter_if.sv
// Bundle of NPORT sram-like master ports plus the single merged sram-like slave port.
// The arbiter connects through the slave modport; whoever drives the masters and
// models the bridge uses the master modport.
interface sram_req_arbiter_if #(
  parameter int unsigned NPORT  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned SW = DATA_W / 8;

  logic [NPORT-1:0]        m_req;
  logic [NPORT-1:0]        m_wr;
  logic [2*NPORT-1:0]      m_size;
  logic [SW*NPORT-1:0]     m_wstrb;
  logic [ADDR_W*NPORT-1:0] m_addr;
  logic [DATA_W*NPORT-1:0] m_wdata;
  logic [NPORT-1:0]        m_addr_ok;
  logic [NPORT-1:0]        m_data_ok;
  logic [DATA_W-1:0]       m_rdata;

  logic                    s_req;
  logic                    s_wr;
  logic [1:0]              s_size;
  logic [SW-1:0]           s_wstrb;
  logic [ADDR_W-1:0]       s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic                    s_addr_ok;
  logic                    s_data_ok;
  logic [DATA_W-1:0]       s_rdata;

  modport slave (
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata,
    output s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  modport master (
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata,
    input  s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// Merges NPORT sram-like masters onto one sram-like slave port. The grant is
// round-robin or fixed-priority, and an in-order ID FIFO routes each response
// back to the master that issued the request.
module sram_req_arbiter #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_OUT   = 4,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                resetn,
  sram_req_arbiter_if.slave   bus,
  output logic                proto_err
);
  localparam int unsigned IDW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned NW  = IDW + 1;
  localparam int unsigned PW  = $clog2(MAX_OUT);
  localparam int unsigned CW  = PW + 1;

  typedef enum logic {ST_OPEN, ST_LOCK} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  lock_id_q, lock_id_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            proto_err_d;
  logic [IDW-1:0]  id_fifo [MAX_OUT];

  logic            grant_any;
  logic [IDW-1:0]  grant_id;
  logic [IDW-1:0]  sel_id;
  logic            sel_valid;
  logic            full;
  logic            s_req_c;
  logic            hs;
  logic            pop;
  logic [IDW-1:0]  head_id;
  logic [2*NPORT-1:0] req_rot;
  logic [NW-1:0]   rr_sum;
  logic [IDW-1:0]  rr_pos;

  // State register: lock, round-robin pointer, FIFO pointers, sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_OPEN;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      proto_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      proto_err <= proto_err_d;
    end
  end

  // ID storage needs no reset: count_q alone marks which entries are valid.
  always_ff @(posedge clk) begin
    if (hs) id_fifo[wptr_q] <= sel_id;
  end

  // Next state: hold the grant while the slave stalls, track outstanding IDs.
  always_comb begin
    state_d     = state_q;
    lock_id_d   = lock_id_q;
    rr_ptr_d    = rr_ptr_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    proto_err_d = proto_err;
    case (state_q)
      ST_OPEN: if (s_req_c && !bus.s_addr_ok) begin
        state_d   = ST_LOCK;
        lock_id_d = grant_id;
      end
      ST_LOCK: if (hs) state_d = ST_OPEN;
      default: state_d = ST_OPEN;
    endcase
    if (hs) begin
      rr_ptr_d = (sel_id == IDW'(NPORT - 1)) ? '0 : sel_id + IDW'(1);
      wptr_d   = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({hs, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (bus.s_data_ok && (count_q == '0)) proto_err_d = 1'b1;
  end

  // Outputs: grant selection, slave field mux, accept and response routing.
  always_comb begin
    grant_any = |bus.m_req;
    grant_id  = '0;
    req_rot   = '0;
    rr_pos    = '0;
    rr_sum    = '0;
    if (PRIO_MODE == 1) begin
      for (int i = NPORT - 1; i >= 0; i--)
        if (bus.m_req[i]) grant_id = IDW'(i);
    end else begin
      req_rot = {bus.m_req, bus.m_req} >> rr_ptr_q;
      for (int i = NPORT - 1; i >= 0; i--)
        if (req_rot[i]) rr_pos = IDW'(i);
      rr_sum = NW'(rr_ptr_q) + NW'(rr_pos);
      if (rr_sum >= NW'(NPORT)) rr_sum = rr_sum - NW'(NPORT);
      grant_id = IDW'(rr_sum);
    end

    full      = (count_q == CW'(MAX_OUT));
    sel_id    = (state_q == ST_LOCK) ? lock_id_q : grant_id;
    sel_valid = (state_q == ST_LOCK) || grant_any;
    s_req_c   = ((state_q == ST_LOCK) ? bus.m_req[lock_id_q] : grant_any) & ~full;
    hs        = s_req_c & bus.s_addr_ok;
    pop       = bus.s_data_ok & (count_q != '0);
    head_id   = id_fifo[rptr_q];

    bus.s_req   = s_req_c;
    bus.s_wr    = 1'b0;
    bus.s_size  = '0;
    bus.s_wstrb = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (sel_valid && (sel_id == IDW'(i))) begin
        bus.s_wr    = bus.m_wr[i];
        bus.s_size  = bus.m_size[2*i +: 2];
        bus.s_wstrb = bus.m_wstrb[(DATA_W/8)*i +: (DATA_W/8)];
        bus.s_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
        bus.s_wdata = bus.m_wdata[DATA_W*i +: DATA_W];
      end
      if (hs && (sel_id == IDW'(i)))   bus.m_addr_ok[i] = 1'b1;
      if (pop && (head_id == IDW'(i))) bus.m_data_ok[i] = 1'b1;
    end
    bus.m_rdata = bus.s_rdata;
  end
endmodule

// File: doc/sram_req_arbiter.md
# sram_req_arbiter

Merges NPORT sram-like master interfaces (instruction fetch, data access, future page-table walker) onto one sram-like slave port in front of the AXI bridge. Arbitration is round-robin or fixed-priority, with an in-order outstanding-request tracker that routes each `data_ok`/`rdata` back to the issuing master. The block is placed between `cpu_core` and the bridge and replaces the current fixed two-interface hookup.

## Interface
- `NPORT`, default 2: number of master ports (2..8). Port 0 is data, port 1 is inst.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width, a multiple of 8.
- `MAX_OUT`, default 4: outstanding-request capacity (power of two, 2..16).
- `PRIO_MODE`, default 0: 0 = round-robin; 1 = fixed priority, lowest index wins.

Ports:
- `clk`  in  1  sole clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `m_req`  in  NPORT  per-master request.
- `m_wr`  in  NPORT  per-master write flag.
- `m_size`  in  2*NPORT  per-master size (0 = byte, 1 = half, 2 = word).
- `m_wstrb`  in  (DATA_W/8)*NPORT  per-master byte strobes.
- `m_addr`  in  ADDR_W*NPORT  per-master address.
- `m_wdata`  in  DATA_W*NPORT  per-master write data.
- `m_addr_ok`  out  NPORT  request accepted, one-hot or zero.
- `m_data_ok`  out  NPORT  response for that master, one-hot or zero.
- `m_rdata`  out  DATA_W  read data, broadcast to all masters.
- `s_req`, `s_wr`, `s_size`, `s_wstrb`, `s_addr`, `s_wdata`  out  1/1/2/DATA_W/8/ADDR_W/DATA_W  slave request fields.
- `s_addr_ok`  in  1  slave accepted the request.
- `s_data_ok`  in  1  slave response, in order.
- `s_rdata`  in  DATA_W  slave read data.
- `proto_err`  out  1  sticky flag: `s_data_ok` arrived with nothing outstanding.

## Operation
- **Handshake.** A request is accepted in any cycle where `req` and `addr_ok` are both high. A master holds `req` and its fields stable until `addr_ok`. The slave returns exactly one `data_ok` per accepted request, writes included, strictly in acceptance order.
- **Grant, unlocked.** The grant is computed combinationally from `m_req`.
  - PRIO_MODE=0: the first requester found scanning upward from `rr_ptr`, wrapping.
  - PRIO_MODE=1: the lowest requesting index.
- **Grant, locked.** If `s_req` is high and `s_addr_ok` is low, the grant is registered (`lock=1`, `lock_id`). `s_*` is then driven from `lock_id` until the handshake, so slave inputs never change mid-request. `lock` clears on the handshake.
- **Round-robin pointer.** On each handshake, `rr_ptr <= grant+1` modulo NPORT. With PRIO_MODE=1 the pointer is unused.
- **Slave request.** `s_req = |m_req & ~full`; when locked, `s_req = m_req[lock_id] & ~full`. The `s_*` fields mux from the granted port.
- **Accept return.** `m_addr_ok[g] = s_addr_ok & s_req` for the granted port g only.
- **Outstanding FIFO.** MAX_OUT entries of `$clog2(NPORT)`-bit port IDs, with `wptr`, `rptr` and `count` (`$clog2(MAX_OUT)+1` bits).
  - Push the grant ID on the handshake.
  - Pop on `s_data_ok` when `count>0`.
  - Pointers wrap modulo MAX_OUT.
- **Full.** `full = (count==MAX_OUT)`; `s_req` is forced to 0. A pop in the same cycle does not lift the gate, so `full` is registered-state only.
- **Simultaneous push and pop.** `count` is unchanged and both pointers advance. This includes the case `count==1`, where the popped ID is the old head, never the new entry.
- **Response.** `m_data_ok[head] = s_data_ok & (count>0)`. `m_rdata = s_rdata` regardless of `data_ok`.
- **Stray response.** `s_data_ok` with `count==0` raises no `m_data_ok` and sets `proto_err`, which holds until reset.
- **Reset.** Asserting `resetn` low mid-operation discards all outstanding IDs. Any later stale `s_data_ok` therefore sets `proto_err`.

## Timing
- The block is zero-latency and purely combinational on these paths:
  - `m_req`/fields to `s_*`
  - `s_addr_ok` to `m_addr_ok`
  - `s_data_ok`/`s_rdata` to `m_data_ok`/`m_rdata`
- State updates at the `clk` posedge: `lock`, `lock_id`, `rr_ptr`, FIFO and `count`, `proto_err`.
- Throughput: one accept per cycle while not full, and one response per cycle.
- Reset values: `lock=0`, `rr_ptr=0`, `count=0`, `wptr=rptr=0`, `proto_err=0`.
  - Outputs with no `m_req` are all 0: `s_req`, `m_addr_ok`, `m_data_ok`.
  - `s_*` fields are 0 when no port is granted (grant defaults to port 0 with `s_req=0`; fields are 0-muxed).
- A master whose `data_ok` coincides with its next `addr_ok` sees both in the same cycle. This is legal.

## Test plan
- **Round-robin accept.** NPORT=2, PRIO_MODE=0; both `m_req` held, `s_addr_ok=1` every cycle. Expect grants 0,1,0,1. `m_addr_ok` toggles `2'b01`,`2'b10`. Four `s_data_ok` return `m_data_ok` 01,10,01,10.
- **Locked grant.** Port 1 requests alone and `s_addr_ok=0` for 3 cycles; port 0 raises `m_req` in cycle 2. Expect `s_addr` = port 1 address throughout. The handshake goes to port 1 (`m_addr_ok=2'b10`). Port 0 is accepted next cycle.
- **Full gating.** MAX_OUT=4, four accepts with no `s_data_ok`. Expect `s_req=0` with a request pending. After one `s_data_ok`, `s_req=1` the next cycle. `count` goes 4→3→4.
- **Push and pop at count 1.** One ID (port 1) outstanding; port 0 handshake and `s_data_ok` in the same cycle. Expect `m_data_ok=2'b10`, `count` stays 1, and the next response goes to port 0.
- **Fixed priority and stray response.** PRIO_MODE=1, NPORT=3, all requesting. Expect port 0 to win every cycle. Then, after reset with `count=0`, pulse `s_data_ok`. Expect `m_data_ok=0` and `proto_err=1` held until `resetn` goes low.
